// File: rtl/mem_stage.sv
// mem_stage: RISC-V MEM stage with req/gnt/rvalid data-memory handshake, store/load formatting and MEM-WB register.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of issuing them.
module mem_stage #(
  parameter int RVALID_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_enable_ip,
  input  logic [3:0]  lsu_operator_ip,
  input  logic [31:0] mem_wdata_ip,
  input  logic [31:0] alu_result_ip,
  input  logic        alu_valid_ip,
  input  logic [1:0]  wb_mux_ip,
  input  logic [4:0]  write_reg_addr_ip,
  input  logic [31:0] pc_addr_ip,
  input  logic [31:0] uimmd_ip,
  output logic        data_req_op,
  output logic        data_we_op,
  output logic [3:0]  data_be_op,
  output logic [31:0] data_addr_op,
  output logic [31:0] data_wdata_op,
  input  logic        data_gnt_ip,
  input  logic        data_rvalid_ip,
  input  logic [31:0] data_rdata_ip,
  output logic        mem_stall_op,
  output logic        mem_err_op,
  output logic        wb_valid_op,
  output logic [31:0] wb_load_data_op,
  output logic [31:0] wb_alu_result_op,
  output logic [1:0]  wb_mux_op,
  output logic [4:0]  wb_write_reg_addr_op,
  output logic [31:0] wb_pc_addr_op,
  output logic [31:0] wb_uimmd_op
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;
  localparam logic [7:0] LIM = 8'(RVALID_TIMEOUT - 1);
  state_t      state_q, nxt;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, wdata_in, shifted, ld_val;
  logic [3:0]  be_q, be_in;
  logic [2:0]  f3_q;
  logic        we_q, req_in, mis, start, bad, tmo, in_gnt, in_rv, ok;
  wire  [1:0]  sz = lsu_operator_ip[1:0];
  wire  [1:0]  off = alu_result_ip[1:0];
  assign in_gnt = state_q == WAIT_GNT;
  assign in_rv = state_q == WAIT_RVALID;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (sz == 2'b01 & off[0]) | (sz == 2'b10 & |off);
`else
  assign mis = 1'b0;
`endif
  // reset gates the combinational request so every output reads 0 while held in reset
  assign req_in = reset & lsu_enable_ip & alu_valid_ip & state_q == IDLE;
  assign start = req_in & ~mis;
  assign bad = req_in & mis;
  assign tmo = (in_gnt & ~data_gnt_ip | in_rv & ~data_rvalid_ip) & cnt_q == LIM;
  assign be_in = sz == 2'b00 ? 4'b0001 << off : sz == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign wdata_in = sz == 2'b00 ? {4{mem_wdata_ip[7:0]}} : sz == 2'b01 ? {2{mem_wdata_ip[15:0]}} : mem_wdata_ip;
  assign data_req_op = start | in_gnt;
  assign data_we_op = in_gnt ? we_q : start & lsu_operator_ip[3];
  assign data_be_op = in_gnt ? be_q : start ? be_in : 4'b0;
  assign data_addr_op = in_gnt ? {addr_q[31:2], 2'b00} : start ? {alu_result_ip[31:2], 2'b00} : 32'b0;
  assign data_wdata_op = in_gnt ? wdata_q : start ? wdata_in : 32'b0;
  assign mem_stall_op = start ? ~(data_gnt_ip & lsu_operator_ip[3]) :
                        in_gnt ? ~(data_gnt_ip & we_q) & ~tmo :
                        in_rv & ~data_rvalid_ip & ~tmo;
  assign mem_err_op = bad | tmo;
  assign ok = ~mem_stall_op & ~mem_err_op;
  assign shifted = data_rdata_ip >> {addr_q[1:0], 3'b000};
  assign ld_val = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} : data_rdata_ip;
  always_comb begin
    nxt = state_q;
    if (start)
      nxt = data_gnt_ip ? (lsu_operator_ip[3] ? IDLE : WAIT_RVALID) : WAIT_GNT;
    else if (in_gnt)
      nxt = data_gnt_ip ? (we_q ? IDLE : WAIT_RVALID) : tmo ? IDLE : WAIT_GNT;
    else if (in_rv)
      nxt = data_rvalid_ip | tmo ? IDLE : WAIT_RVALID;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      wb_valid_op <= 1'b0;
      wb_load_data_op <= '0;
      wb_alu_result_op <= '0;
      wb_mux_op <= '0;
      wb_write_reg_addr_op <= '0;
      wb_pc_addr_op <= '0;
      wb_uimmd_op <= '0;
    end else begin
      state_q <= nxt;
      cnt_q <= (state_q == IDLE || nxt != state_q) ? 8'd0 : cnt_q + 8'd1;
      if (start) begin
        addr_q <= alu_result_ip;
        wdata_q <= wdata_in;
        be_q <= be_in;
        f3_q <= lsu_operator_ip[2:0];
        we_q <= lsu_operator_ip[3];
      end
      wb_valid_op <= ok & alu_valid_ip;
      wb_load_data_op <= ok & in_rv ? ld_val : 32'b0;
      wb_alu_result_op <= ok ? alu_result_ip : 32'b0;
      wb_mux_op <= ok ? wb_mux_ip : 2'b0;
      wb_write_reg_addr_op <= ok ? write_reg_addr_ip : 5'b0;
      wb_pc_addr_op <= ok ? pc_addr_ip : 32'b0;
      wb_uimmd_op <= ok ? uimmd_ip : 32'b0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (default build, RVALID_TIMEOUT=16).
module tb_mem_stage;
  logic        clock, reset;
  logic        lsu_enable_ip, alu_valid_ip, data_gnt_ip, data_rvalid_ip;
  logic [3:0]  lsu_operator_ip;
  logic [31:0] mem_wdata_ip, alu_result_ip, pc_addr_ip, uimmd_ip, data_rdata_ip;
  logic [1:0]  wb_mux_ip;
  logic [4:0]  write_reg_addr_ip;
  logic        data_req_op, data_we_op, mem_stall_op, mem_err_op, wb_valid_op;
  logic [3:0]  data_be_op;
  logic [31:0] data_addr_op, data_wdata_op, wb_load_data_op, wb_alu_result_op, wb_pc_addr_op, wb_uimmd_op;
  logic [1:0]  wb_mux_op;
  logic [4:0]  wb_write_reg_addr_op;
  int checks = 0, errors = 0;
  mem_stage #(.RVALID_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .lsu_enable_ip(lsu_enable_ip), .lsu_operator_ip(lsu_operator_ip), .mem_wdata_ip(mem_wdata_ip),
    .alu_result_ip(alu_result_ip), .alu_valid_ip(alu_valid_ip), .wb_mux_ip(wb_mux_ip),
    .write_reg_addr_ip(write_reg_addr_ip), .pc_addr_ip(pc_addr_ip), .uimmd_ip(uimmd_ip),
    .data_req_op(data_req_op), .data_we_op(data_we_op), .data_be_op(data_be_op),
    .data_addr_op(data_addr_op), .data_wdata_op(data_wdata_op), .data_gnt_ip(data_gnt_ip),
    .data_rvalid_ip(data_rvalid_ip), .data_rdata_ip(data_rdata_ip), .mem_stall_op(mem_stall_op),
    .mem_err_op(mem_err_op), .wb_valid_op(wb_valid_op), .wb_load_data_op(wb_load_data_op),
    .wb_alu_result_op(wb_alu_result_op), .wb_mux_op(wb_mux_op),
    .wb_write_reg_addr_op(wb_write_reg_addr_op), .wb_pc_addr_op(wb_pc_addr_op), .wb_uimmd_op(wb_uimmd_op)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic load(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    lsu_enable_ip = 1'b1; lsu_operator_ip = op; alu_result_ip = a; data_gnt_ip = 1'b1;
    #1;
    chk({tag, "_req"}, data_req_op, 1);
    chk({tag, "_addr"}, data_addr_op, {a[31:2], 2'b00});
    chk({tag, "_stall_gnt"}, mem_stall_op, 1);
    tick;
    chk({tag, "_bubble"}, wb_valid_op, 0);
    data_gnt_ip = 1'b0; data_rvalid_ip = 1'b1; data_rdata_ip = rd;
    #1;
    chk({tag, "_stall_rv"}, mem_stall_op, 0);
    tick;
    chk({tag, "_data"}, wb_load_data_op, exp);
    chk({tag, "_valid"}, wb_valid_op, 1);
    lsu_enable_ip = 1'b0; data_rvalid_ip = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    {lsu_enable_ip, alu_valid_ip, data_gnt_ip, data_rvalid_ip} = '0;
    lsu_operator_ip = '0; mem_wdata_ip = '0; alu_result_ip = '0; pc_addr_ip = '0;
    uimmd_ip = '0; data_rdata_ip = '0; wb_mux_ip = '0; write_reg_addr_ip = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_req", data_req_op, 0);
    chk("rst_stall", mem_stall_op, 0);
    tick;
    chk("rst_wb_valid", wb_valid_op, 0);
    chk("rst_wb_mux", wb_mux_op, 0);
    reset = 1'b1;
    // SW 0x100, granted in the same cycle
    alu_valid_ip = 1'b1; write_reg_addr_ip = 5'd5; pc_addr_ip = 32'h40; uimmd_ip = 32'h1000;
    lsu_enable_ip = 1'b1; lsu_operator_ip = 4'b1010; alu_result_ip = 32'h100;
    mem_wdata_ip = 32'hDEADBEEF; data_gnt_ip = 1'b1;
    #1;
    chk("sw_req", data_req_op, 1);
    chk("sw_we", data_we_op, 1);
    chk("sw_be", data_be_op, 4'b1111);
    chk("sw_addr", data_addr_op, 32'h100);
    chk("sw_wdata", data_wdata_op, 32'hDEADBEEF);
    chk("sw_stall", mem_stall_op, 0);
    tick;
    chk("sw_wb_valid", wb_valid_op, 1);
    chk("sw_wb_rd", wb_write_reg_addr_op, 5);
    chk("sw_wb_pc", wb_pc_addr_op, 32'h40);
    // SB 0x103, grant arrives after two waiting cycles
    lsu_operator_ip = 4'b1000; alu_result_ip = 32'h103; mem_wdata_ip = 32'h000000A5; data_gnt_ip = 1'b0;
    #1;
    chk("sb_be", data_be_op, 4'b1000);
    chk("sb_wdata", data_wdata_op, 32'hA5A5A5A5);
    chk("sb_stall1", mem_stall_op, 1);
    tick;
    chk("sb_bubble1_valid", wb_valid_op, 0);
    chk("sb_bubble1_rd", wb_write_reg_addr_op, 0);
    mem_wdata_ip = 32'h0;
    #1;
    chk("sb_hold_req", data_req_op, 1);
    chk("sb_hold_be", data_be_op, 4'b1000);
    chk("sb_hold_wdata", data_wdata_op, 32'hA5A5A5A5);
    chk("sb_hold_addr", data_addr_op, 32'h100);
    chk("sb_stall2", mem_stall_op, 1);
    tick;
    chk("sb_bubble2_valid", wb_valid_op, 0);
    data_gnt_ip = 1'b1;
    #1;
    chk("sb_gnt_stall", mem_stall_op, 0);
    chk("sb_gnt_req", data_req_op, 1);
    tick;
    chk("sb_done_valid", wb_valid_op, 1);
    chk("sb_done_rd", wb_write_reg_addr_op, 5);
    // SH 0x102
    lsu_operator_ip = 4'b1001; alu_result_ip = 32'h102; mem_wdata_ip = 32'hFFFF1234;
    #1;
    chk("sh_be", data_be_op, 4'b1100);
    chk("sh_wdata", data_wdata_op, 32'h12341234);
    tick;
    lsu_enable_ip = 1'b0; data_gnt_ip = 1'b0;
    // loads, rvalid one cycle after gnt
    load("lb", 4'b0000, 32'h202, 32'h00800000, 32'hFFFFFF80);
    load("lbu", 4'b0100, 32'h202, 32'h00800000, 32'h00000080);
    load("lh", 4'b0001, 32'h202, 32'h80011234, 32'hFFFF8001);
    load("lhu", 4'b0101, 32'h202, 32'h80011234, 32'h00008001);
    load("lw", 4'b0010, 32'h200, 32'h80011234, 32'h80011234);
    // load granted, rvalid never arrives
    lsu_enable_ip = 1'b1; lsu_operator_ip = 4'b0010; alu_result_ip = 32'h300; data_gnt_ip = 1'b1;
    tick;
    data_gnt_ip = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (i == 0 || i == 14) begin
        chk("to_wait_err", mem_err_op, 0);
        chk("to_wait_stall", mem_stall_op, 1);
      end
      @(posedge clock);
    end
    #1;
    chk("to_err", mem_err_op, 1);
    chk("to_stall_released", mem_stall_op, 0);
    tick;
    chk("to_bubble_valid", wb_valid_op, 0);
    chk("to_bubble_rd", wb_write_reg_addr_op, 0);
    // late rvalid in IDLE alongside a non-memory instruction
    lsu_enable_ip = 1'b0; data_rvalid_ip = 1'b1; data_rdata_ip = 32'hCAFEF00D;
    alu_result_ip = 32'h1234; write_reg_addr_ip = 5'd7; wb_mux_ip = 2'd2;
    #1;
    chk("alu_err", mem_err_op, 0);
    chk("alu_req", data_req_op, 0);
    chk("alu_stall", mem_stall_op, 0);
    tick;
    chk("alu_valid", wb_valid_op, 1);
    chk("alu_result", wb_alu_result_op, 32'h1234);
    chk("alu_mux", wb_mux_op, 2);
    chk("alu_rd", wb_write_reg_addr_op, 7);
    chk("alu_load", wb_load_data_op, 0);
    data_rvalid_ip = 1'b0;
    // misaligned LW 0x101
    lsu_enable_ip = 1'b1; lsu_operator_ip = 4'b0010; alu_result_ip = 32'h101; data_gnt_ip = 1'b0;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req", data_req_op, 0);
    chk("mis_err", mem_err_op, 1);
    chk("mis_stall", mem_stall_op, 0);
    tick;
    chk("mis_bubble", wb_valid_op, 0);
`else
    chk("mis_req", data_req_op, 1);
    chk("mis_addr", data_addr_op, 32'h100);
    chk("mis_err", mem_err_op, 0);
    tick;
    // now in WAIT_GNT; an async reset drops the request at once
    reset = 1'b0;
    #1;
    chk("rst_mid_req", data_req_op, 0);
    chk("rst_mid_stall", mem_stall_op, 0);
    lsu_enable_ip = 1'b0;
    reset = 1'b1;
    tick;
    chk("rst_mid_idle_req", data_req_op, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISCV core, directly downstream of the execute stage.
- Consumes the EX-MEM buffer outputs and drives the data-memory request/grant/valid handshake.
- Formats store data with byte enables, then aligns and sign-extends load data.
- Stalls the upstream stages while a transaction is outstanding and drives the MEM-WB pipeline buffer.

Parameters:
- RVALID_TIMEOUT, 16: maximum cycles to wait for data_gnt_ip or data_rvalid_ip before aborting with mem_err_op; legal range 2..255.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lsu_enable_ip  in  1  memory operation present.
- lsu_operator_ip  in  4  {is_store, funct3}; funct3 encodes 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_wdata_ip  in  32  store data (rs2).
- alu_result_ip  in  32  effective address, or non-memory result.
- alu_valid_ip  in  1  instruction valid in MEM.
- wb_mux_ip  in  write_back_mux_selector  writeback source select.
- write_reg_addr_ip  in  5  destination register.
- pc_addr_ip  in  32  instruction PC.
- uimmd_ip  in  32  upper immediate.
- data_req_op  out  1  memory request.
- data_we_op  out  1  1 = store.
- data_be_op  out  4  byte enables.
- data_addr_op  out  32  word-aligned address ({addr[31:2],2'b00}).
- data_wdata_op  out  32  lane-replicated store data.
- data_gnt_ip  in  1  request accepted.
- data_rvalid_ip  in  1  read data valid.
- data_rdata_ip  in  32  read data.
- mem_stall_op  out  1  hold IF/ID/EX and EX-MEM.
- mem_err_op  out  1  one-cycle pulse on timeout or misalignment.
- wb_valid_op  out  1  MEM-WB valid.
- wb_load_data_op  out  32  aligned, extended load data.
- wb_alu_result_op  out  32  ALU result passed through.
- wb_mux_op  out  write_back_mux_selector  passed through.
- wb_write_reg_addr_op  out  5  destination register; 0 for a bubble.
- wb_pc_addr_op  out  32  PC passed through.
- wb_uimmd_op  out  32  immediate passed through.

Behaviour:
- Reset (reset=0, async): FSM goes to IDLE, timeout counter to 0. All outputs are 0, including wb_mux_op at encoding 0.
- FSM states and transitions:
  - IDLE:
    - If lsu_enable_ip & alu_valid_ip, drive data_req_op=1 combinationally with addr/we/be/wdata derived from the inputs.
    - gnt in the same cycle, store: complete, no stall.
    - gnt in the same cycle, load: go to WAIT_RVALID, mem_stall_op=1.
    - No gnt: latch the request into internal registers, go to WAIT_GNT, mem_stall_op=1.
  - WAIT_GNT:
    - Keep data_req_op=1 with the latched values (stable until gnt); mem_stall_op=1.
    - On gnt: a store returns to IDLE (completes this cycle, stall drops); a load goes to WAIT_RVALID.
  - WAIT_RVALID:
    - data_req_op=0, mem_stall_op=1.
    - On data_rvalid_ip: capture the formatted data into MEM-WB, drop the stall this cycle, return to IDLE.
    - rvalid in the same cycle as gnt is not allowed (data arrives no earlier than 1 cycle after gnt).
- Timeout counter:
  - Clears on every state entry and increments each cycle in WAIT_*.
  - Reaching RVALID_TIMEOUT pulses mem_err_op, writes a bubble to MEM-WB, returns to IDLE and releases the stall.
- Store formatting:
  - SB: be = 0001 << addr[1:0]; wdata = the low byte replicated x4.
  - SH: be = 0011 << {addr[1],1'b0}; wdata = the low halfword replicated x2.
  - SW: be = 1111.
- Load formatting:
  - Shift rdata right by 8*addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes rdata unchanged.
- Non-memory instruction (lsu_enable_ip=0): no request; MEM-WB captures the pass-through fields next edge; wb_load_data_op=0.
- MEM-WB register:
  - Updates every edge.
  - While mem_stall_op=1 it loads a bubble (wb_valid_op=0, wb_write_reg_addr_op=0).
  - On completion it loads the real instruction with wb_valid_op=alu_valid_ip.
- Latency: store/ALU op = 1 cycle to MEM-WB with 0-cycle gnt; load = 1 + gnt wait + rvalid wait cycles.
- Reset mid-transaction drops the request immediately; a late rvalid arriving in IDLE is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request.
  - mem_err_op pulses for one cycle and MEM-WB receives a bubble. No stall.
- Undefined:
  - No check. addr[1:0] still drives lane selection; byte enables that shift past bit 3 are truncated.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle -> data_be_op=1111, data_addr_op=0x100, no stall, wb_valid_op=1 next edge.
- SB addr 0x103, data 0x000000A5, gnt after 2 cycles -> data_be_op=1000, data_wdata_op=0xA5A5A5A5 held stable, mem_stall_op=1 for 2 cycles, two bubbles then completion.
- LB addr 0x202, rdata 0x00800000 one cycle after gnt -> wb_load_data_op=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH addr 0x202, rdata 0x8001xxxx -> wb_load_data_op=0xFFFF8001. LW -> the rdata value unchanged.
- Load granted but rvalid never asserted, RVALID_TIMEOUT=16 -> mem_err_op pulses at cycle 16, stall released, bubble written, FSM back to IDLE.
- LW addr 0x101 -> with MEM_MISALIGN_TRAP_EN: no data_req_op, mem_err_op=1, bubble. Without it: request issued to 0x100.
